mmult_sched: RTL
================

# mmult_sched

Two-port round-robin scheduler that shares one 3×3 matrix-multiply engine (8-bit operands, 18-bit results, 4-cycle enable-driven sequence) between two requesters. It latches the winner's operands and drives the engine's enable until the engine reports valid. It then returns the packed result to the winner with a one-cycle done pulse and releases the engine cleanly so the next job starts from the engine's first row. It sits between the lab's input front-ends (UART/button loaders) and the multiplier.

## Interface
- DW, 8, operand element width
- CW, 18, result element width (2·DW+2, holds 3·255² = 195075)
- TIMEOUT, 15, RUN-state cycle limit (used only with the timeout macro)
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  2  per-requester job request, held until matching gnt bit
- a_in0, b_in0, a_in1, b_in1  in  9·DW each  row-major operand matrices, element 0 in MSBs
- gnt  out  2  one-hot, one-cycle pulse: operands of that requester latched
- done  out  2  one-hot, one-cycle pulse: res valid for that requester
- err  out  1  high with done when job timed out (tied 0 without macro)
- res  out  9·CW  packed result C[0]..C[8], C[0] in MSBs, stable until next done
- eng_enable  out  1  engine enable
- eng_a, eng_b  out  9·DW  latched operands to engine
- eng_valid  in  1  engine result valid
- eng_c  in  9·CW  engine result

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if any req, grant via round-robin → latch the winner's a/b into eng_a/eng_b, pulse gnt, set eng_enable=1 → RUN. eng_valid is ignored in IDLE.
- Arbitration: single request wins outright. On a tie, grant the requester not granted last. The last-grant pointer resets to 1, so requester 0 wins the first tie.
- RUN: hold eng_enable=1 and operands constant. On eng_valid=1: eng_enable←0, res←eng_c, pulse done[winner] → DONE.
- DONE: one cycle with eng_enable=0, so the engine clears valid and sits at its first step → IDLE.
- A requester dropping req before gnt withdraws with no side effects. req asserted during RUN/DONE waits.
- Operand inputs are sampled only at the grant edge.

## Timing
- Reset values: gnt=0, done=0, err=0, res=0, eng_enable=0, eng_a=eng_b=0, state IDLE, pointer=1. Reset mid-job aborts immediately; no done is issued.
- Edge k: req sampled in IDLE → gnt, eng_enable high after k.
- Edges k+1..k+4: engine sequence; eng_valid seen high after k+4.
- Edge k+5: done/res updated.
- Edge k+6: DONE → IDLE.
- Edge k+7: earliest next grant. Throughput is 1 job per 7 cycles; grant-to-done latency is 5 cycles.
- gnt and done never coincide for the same requester.

## Configuration
- MMULT_SCHED_TIMEOUT_EN defined: a counter clears on entry to RUN and increments each RUN cycle. If it reaches TIMEOUT without eng_valid: eng_enable←0, res unchanged, done[winner] and err pulse together → DONE.
- Undefined: no counter; RUN waits indefinitely; err constant 0.

## Structure
- mmult_pkg holds the state enum (IDLE/RUN/DONE), DW/CW defaults, and derived widths MAT_A_W=72 and MAT_C_W=162.
- Sub-module rr_arb2 is the 2-way round-robin arbiter. Combinational grant from req + pointer; the pointer updates on the accept strobe.

## Test plan
- Single job: req=01, A=identity, B=1..9 → gnt=01 after edge k, done=01 after k+5, res = 1..9 (18-bit each), err=0.
- Tie after reset: req=11 → gnt=01 at k, done=01 at k+5, gnt=10 at k+7, done=10 at k+12.
- Sustained contention, both always requesting for 6 jobs → grants alternate 0,1,0,1,0,1. Results match a software model for random operands.
- Max values: all elements 255 in both matrices → every C element 195075, no truncation.
- Reset mid-RUN: reset_n low at k+3 → all outputs 0 immediately. After release, a fresh req=10 completes normally with a correct result.
- MMULT_SCHED_TIMEOUT_EN with an engine stub whose valid never rises → done and err pulse after edge k+TIMEOUT. res is unchanged and eng_enable is 0 in DONE.

Source files
------------

// File: rtl/mmult_sched_pkg.sv
// Shared types and widths for the 3x3 matrix-multiply scheduler.
// Holds the FSM state enum and the default/derived operand widths.
package mmult_pkg;

    localparam int DW      = 8;
    localparam int CW      = 2 * DW + 2;
    localparam int MAT_A_W = 9 * DW;
    localparam int MAT_C_W = 9 * CW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mmult_sched_if.sv
// Requester-side bundle of the scheduler: job requests, operands,
// grant/done pulses and the shared result bus.
interface mmult_sched_if #(
    parameter int DW = 8,
    parameter int CW = 18
);
    logic [1:0]      req;
    logic [9*DW-1:0] a_in0;
    logic [9*DW-1:0] b_in0;
    logic [9*DW-1:0] a_in1;
    logic [9*DW-1:0] b_in1;
    logic [1:0]      gnt;
    logic [1:0]      done;
    logic            err;
    logic [9*CW-1:0] res;

    modport master (
        output req, a_in0, b_in0, a_in1, b_in1,
        input  gnt, done, err, res
    );

    modport slave (
        input  req, a_in0, b_in0, a_in1, b_in1,
        output gnt, done, err, res
    );
endinterface

// File: rtl/mmult_sched_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from req and the
// last-grant pointer; the pointer moves only when a grant is accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);
    // last = 1 means requester 1 won most recently, so 0 wins a tie
    logic last;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= 1'b1;
        end else if (accept && (gnt != 2'b00)) begin
            last <= gnt[1];
        end
    end
endmodule

// File: rtl/mmult_sched.sv
// Round-robin scheduler sharing one 3x3 matrix-multiply engine between two
// requesters. Optional RUN watchdog: define MMULT_SCHED_TIMEOUT_EN.
module mmult_sched
    import mmult_pkg::*;
#(
    parameter int DW      = mmult_pkg::DW,
    parameter int CW      = mmult_pkg::CW,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset_n,
    mmult_sched_if.slave    bus,
    output logic            eng_enable,
    output logic [9*DW-1:0] eng_a,
    output logic [9*DW-1:0] eng_b,
    input  logic            eng_valid,
    input  logic [9*CW-1:0] eng_c
);
    state_e          state;
    logic [1:0]      owner;
    logic [1:0]      arb_gnt;
    logic            accept;
    logic            tmo;
    logic [1:0]      gnt_q;
    logic [1:0]      done_q;
    logic            err_q;
    logic [9*CW-1:0] res_q;

    assign accept   = (state == IDLE) && (bus.req != 2'b00);
    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.res  = res_q;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.req),
        .accept  (accept),
        .gnt     (arb_gnt)
    );

`ifdef MMULT_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;

    // Held at zero outside RUN, so it restarts on every entry to RUN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt <= '0;
        end else if (state != RUN) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign tmo = (state == RUN) && !eng_valid
              && (tcnt == TW'(TIMEOUT - 1));
`else
    assign tmo = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= 2'b00;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            err_q      <= 1'b0;
            res_q      <= '0;
            eng_enable <= 1'b0;
            eng_a      <= '0;
            eng_b      <= '0;
        end else begin
            gnt_q  <= 2'b00;
            done_q <= 2'b00;
            err_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= arb_gnt;
                        gnt_q      <= arb_gnt;
                        eng_a      <= arb_gnt[1] ? bus.a_in1 : bus.a_in0;
                        eng_b      <= arb_gnt[1] ? bus.b_in1 : bus.b_in0;
                        eng_enable <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (eng_valid) begin
                        eng_enable <= 1'b0;
                        res_q      <= eng_c;
                        done_q     <= owner;
                        state      <= DONE;
                    end else if (tmo) begin
                        eng_enable <= 1'b0;
                        done_q     <= owner;
                        err_q      <= 1'b1;
                        state      <= DONE;
                    end
                end
                // Engine sees enable low here and drops back to its first row
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
